// File: rtl/logic_pkg.sv
// Shared types for the bitwise logic stage and the result FIFO behind it.
package logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [15:0] data;
    } result_t;

    localparam int unsigned RESULT_W = 18;

endpackage

// File: rtl/result_ram.sv
// DEPTH x result_t storage: one synchronous write port, one asynchronous read port.
module result_ram
    import logic_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  result_t       wdata,
    input  logic [AW-1:0] raddr,
    output result_t       rdata_c
);

    result_t mem_q [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the FIFO count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/logic_result_fifo.sv
// First-word-fall-through FIFO buffering logic-stage results with their op codes.
module logic_result_fifo
    import logic_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  op_t              in_op,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output op_t              out_op,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          push, pop;
    result_t       wr_result;
    result_t       rd_result;

    // Next-state: flush wins over any push/pop in the same cycle.
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d  = (count_d != CW'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign wr_result = '{op: in_op, data: 16'(in_data)};

    result_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we      (push && !flush),
        .waddr   (wr_ptr_q),
        .wdata   (wr_result),
        .raddr   (rd_ptr_q),
        .rdata_c (rd_result)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign out_data  = WIDTH'(rd_result.data);
    assign out_op    = rd_result.op;

endmodule

// File: tb/tb_logic_result_fifo.sv
// Self-checking bench for logic_result_fifo against a queue-based reference model.
module tb_logic_result_fifo;
    import logic_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    op_t         in_op;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    op_t         out_op;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    result_t mq[$];
    result_t popped[$];

    logic_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference behaviour at a rising edge, decided from the pre-edge occupancy.
    task automatic model_edge();
        bit do_push, do_pop;
        if (!reset || flush) begin
            mq.delete();
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = out_ready && (mq.size() > 0);
            if (do_pop) popped.push_back(mq.pop_front());
            if (do_push) mq.push_back('{op: in_op, data: in_data});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'hdead;
        in_op = OP_XOR; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d count=%0d in_ready=%b out_valid=%b required 0/1/0",
                         i, count, in_ready, out_valid);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 16'hdead || out_op !== OP_XOR) begin
            errors++;
            $display("FAIL reset_release count=%0d out_valid=%b data=%h op=%0d required 1/1/dead/%0d",
                     count, out_valid, out_data, out_op, OP_XOR);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain count=%0d out_valid=%b required 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] words [5];
        op_t         ops   [5];
        bit          accepted;
        int          cyc;
        words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        ops   = '{OP_AND, OP_OR, OP_XOR, OP_NAND, OP_AND};
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = words[i]; in_op = ops[i];
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_count i=%0d count=%0d required %0d", i, count, i + 1);
            end
        end
        in_data = words[4]; in_op = ops[4];
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 3'd4 || in_ready !== 1'b0 || out_data !== 16'h1111) begin
                errors++;
                $display("FAIL full_hold count=%0d in_ready=%b head=%h required 4/0/1111",
                         count, in_ready, out_data);
            end
        end
        popped.delete();
        out_ready = 1'b1;
        accepted  = 1'b0;
        cyc       = 0;
        while (!(accepted && mq.size() == 0) && cyc < 20) begin
            checks++;
            if (count !== 3'(mq.size()) ||
                (mq.size() > 0 && (out_data !== mq[0].data || out_op !== mq[0].op))) begin
                errors++;
                $display("FAIL drain cyc=%0d count=%0d data=%h required count=%0d",
                         cyc, count, out_data, mq.size());
            end
            if (in_valid && mq.size() < DEPTH) accepted = 1'b1;
            tick();
            if (accepted) in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (cyc >= 20 || count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end cyc=%0d count=%0d out_valid=%b required empty", cyc, count, out_valid);
        end
        checks++;
        if (popped.size() != 5) begin
            errors++;
            $display("FAIL drain_len got=%0d required 5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (popped[i].data !== words[i] || popped[i].op !== ops[i]) begin
                    errors++;
                    $display("FAIL drain_order i=%0d got=%h/%0d required %h/%0d",
                             i, popped[i].data, popped[i].op, words[i], ops[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        popped.delete();
        in_valid = 1'b1; out_ready = 1'b0; in_op = OP_OR;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
            checks++;
            if (count !== 3'd2 || out_data !== 16'h0100 + 16'(i - 1)) begin
                errors++;
                $display("FAIL b2b i=%0d count=%0d head=%h required 2/%h",
                         i, count, out_data, 16'h0100 + 16'(i - 1));
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || popped.size() != 12) begin
            errors++;
            $display("FAIL b2b_end count=%0d popped=%0d required 0/12", count, popped.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (popped[i].data !== 16'h0100 + 16'(i)) begin
                    errors++;
                    $display("FAIL b2b_order i=%0d got=%h required %h", i, popped[i].data, 16'h0100 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_full_pop_and_flush();
        result_t head;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'($urandom); in_op = op_t'($urandom_range(0, 3));
            tick();
        end
        popped.delete();
        head = mq[0];
        in_data = 16'hcafe; out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 3'd3 || popped.size() != 1 || popped[0] !== head ||
            mq.size() != 3 || mq[2].data === 16'hcafe) begin
            errors++;
            $display("FAIL full_pop count=%0d required 3 (push refused, head %h popped)", count, head.data);
        end
        flush = 1'b1; in_data = 16'hbeef;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush count=%0d out_valid=%b in_ready=%b required 0/0/1", count, out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = 16'h7777; in_op = OP_NAND;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_data !== 16'h7777 || out_op !== OP_NAND) begin
            errors++;
            $display("FAIL post_flush count=%0d head=%h required 1/7777", count, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'ha000 + 16'(i); in_op = OP_AND;
            tick();
        end
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL async_pre count=%0d required 2", count);
        end
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset count=%0d out_valid=%b in_ready=%b required 0/0/1",
                     count, out_valid, in_ready);
        end
        in_valid = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h4242; in_op = OP_XOR;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_data !== 16'h4242 || out_op !== OP_XOR) begin
            errors++;
            $display("FAIL async_resume count=%0d head=%h required 1/4242", count, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = 16'($urandom);
            in_op     = op_t'($urandom_range(0, 3));
            checks++;
            if (count !== 3'(mq.size()) || in_ready !== (mq.size() != DEPTH) ||
                out_valid !== (mq.size() != 0) ||
                (mq.size() > 0 && (out_data !== mq[0].data || out_op !== mq[0].op))) begin
                errors++;
                $display("FAIL random i=%0d count=%0d rdy=%b vld=%b head=%h required count=%0d head=%h",
                         i, count, in_ready, out_valid, out_data, mq.size(),
                         (mq.size() > 0) ? mq[0].data : 16'h0);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop_and_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_result_fifo.md
# logic_result_fifo

Buffers results from the combinational bitwise logic stage (AND/OR/XOR/NAND selected by a 2-bit op) together with the op code that produced them. It decouples that stage from a slower downstream consumer. A valid/ready handshake is used on both sides, and the output is first-word-fall-through. Inserted directly downstream of the logic stage; the producer drives `in_data` from the logic result and `in_op` from its select.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `WIDTH`, 16, result data width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset (asserted when 0)
- `flush` in 1: synchronous clear of all entries
- `in_valid` in 1: producer has a result
- `in_data` in WIDTH: result word
- `in_op` in 2: op code (`op_t`) that produced `in_data`
- `in_ready` out 1: FIFO can accept a push this cycle
- `out_valid` out 1: head entry available
- `out_data` out WIDTH: head entry data
- `out_op` out 2: head entry op
- `out_ready` in 1: consumer takes head this cycle
- `count` out $clog2(DEPTH)+1: number of stored entries, 0..DEPTH

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`; `out_valid = (count != 0)`. Both are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- `out_data`/`out_op` always show the entry at the read pointer. They are don't-care when `out_valid = 0` and are not required to be zero.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, or derived from pointers with an extra wrap bit.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and `count` is unchanged.
- When full, `in_ready = 0`, so a push is refused even if a pop happens the same cycle. There is no full-bypass.
- When empty, a pop is impossible (`out_valid = 0`) and a push is not passed through combinationally.
- Holding data under stall: while `in_valid && !in_ready`, the producer holds `in_data`/`in_op`. The FIFO has no drop or overflow path.
- `flush = 1` at a rising edge: pointers and `count` go to 0. Any push or pop in that cycle is discarded. `flush` takes precedence over push and pop.
- `reset = 0` at any time, including mid-push or mid-pop: pointers and `count` clear immediately. Storage contents are not reset.

## Timing
- Reset values: `count = 0`, `in_ready = 1`, `out_valid = 0`. `out_data`/`out_op` are don't-care.
- Latency: a word pushed at edge N into an empty FIFO gives `out_valid = 1` after edge N, so it can be popped at edge N+1. Minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle in steady state.
- `count` updates at the same edge as the push or pop. `in_ready` and `out_valid` reflect the new `count` immediately after that edge.
- Reset release: the first push is accepted at the first rising edge with `reset = 1`.

## Structure
- Package `logic_pkg` contains:
  - `op_t` enum (2 bits): `OP_AND = 2'b00`, `OP_OR = 2'b01`, `OP_XOR = 2'b10`, `OP_NAND = 2'b11`
  - `result_t` packed struct {`op_t op`; `logic [15:0] data`}
  - `localparam RESULT_W = 18`
- The logic stage and this FIFO both import `logic_pkg`.
- Sub-module `result_ram`: DEPTH × `result_t` storage with one synchronous write port and one asynchronous read port.
- Pointers, `count` and flags live in `logic_result_fifo`.

## Test plan
- Reset: hold `reset = 0` for 3 cycles with `in_valid = 1`. Required: `count = 0`, `in_ready = 1`, `out_valid = 0`. No push occurs until release.
- Fill and drain:
  - Push `{OP_AND, 16'h1111}`, `{OP_OR, 16'h2222}`, `{OP_XOR, 16'h3333}`, `{OP_NAND, 16'h4444}` with `out_ready = 0`. Required: `count = 4`, `in_ready = 0`.
  - A 5th word `16'h5555` is held and not accepted.
  - Then set `out_ready = 1`. Required: words pop in order with matching ops, `count` steps 4→0, and `16'h5555` is accepted once `in_ready` returns.
- Simultaneous push/pop at `count = 2` for 10 cycles with incrementing data. Required: `count` stays 2 and output order equals input order across pointer wrap.
- Full plus pop: at `count = 4`, assert `in_valid` and `out_ready` together. Required: the pop happens, the push is refused, and `count = 3`.
- Flush: at `count = 3`, assert `flush` together with `in_valid` and `out_ready`. Required: next cycle `count = 0`, `out_valid = 0`, and the flushed words never appear.
- Async reset mid-stream: drop `reset` between edges while `count = 2`. Required: `count = 0` and `out_valid = 0` before the next edge; normal operation resumes after release.
